// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV64I-subset datapath: one instruction in flight, Moore-decoded strobes.
// Optional macro WAIT_STATE_EN: FETCH, MEM_READ and MEM_WRITE stall until mem_ready.
`default_nettype none

module controle_multiciclo (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IMemOut,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        BranchNe,
   output logic        PCSource,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic [1:0]  MemToReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        Halted,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_EXEC_I    = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_WB_LOAD   = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_WB_ALU    = 4'd9,
      S_BRANCH    = 4'd10,
      S_LUI       = 4'd11,
      S_HALT      = 4'd12
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   state_t     state;
   logic       branch_ne_q;
   logic       mem_done;
   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = IMemOut[6:0];
   assign funct3 = IMemOut[14:12];

`ifdef WAIT_STATE_EN
   assign mem_done = mem_ready;
   logic unused_inputs;
   assign unused_inputs = ^{IMemOut[31:15], IMemOut[11:7]};
`else
   assign mem_done = 1'b1;
   logic unused_inputs;
   assign unused_inputs = ^{mem_ready, IMemOut[31:15], IMemOut[11:7]};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_RESET;
         branch_ne_q <= 1'b0;
      end else begin
         case (state)
            S_RESET:     state <= S_FETCH;
            S_FETCH:     if (mem_done) state <= S_DECODE;
            S_DECODE: begin
               // funct3[0] distinguishes bne from beq; held until the BRANCH cycle
               branch_ne_q <= funct3[0];
               case (opcode)
                  OP_R:               state <= S_EXEC_R;
                  OP_I:               state <= S_EXEC_I;
                  OP_LOAD, OP_STORE:  state <= S_MEM_ADDR;
                  OP_BRANCH:          state <= (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                  OP_LUI:             state <= S_LUI;
                  default:            state <= S_HALT;
               endcase
            end
            S_EXEC_R:    state <= S_WB_ALU;
            S_EXEC_I:    state <= S_WB_ALU;
            S_WB_ALU:    state <= S_FETCH;
            S_MEM_ADDR:  state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_done) state <= S_WB_LOAD;
            S_WB_LOAD:   state <= S_FETCH;
            S_MEM_WRITE: if (mem_done) state <= S_FETCH;
            S_BRANCH:    state <= S_FETCH;
            S_LUI:       state <= S_FETCH;
            default:     state <= S_HALT;
         endcase
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      PCSource    = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      MemToReg    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      Halted      = 1'b0;
      case (state)
         S_FETCH: begin
            // PC and IR load only on the completing cycle so a stalled fetch advances PC once
            MemRead = 1'b1;
            IRWrite = mem_done;
            PCWrite = mem_done;
            ALUSrcB = 2'b01;
         end
         S_DECODE:    ALUSrcB = 2'b11;
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b10;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_READ:  MemRead = 1'b1;
         S_WB_LOAD: begin
            RegWrite = 1'b1;
            MemToReg = 2'b01;
         end
         S_MEM_WRITE: MemWrite = 1'b1;
         S_WB_ALU:    RegWrite = 1'b1;
         S_BRANCH: begin
            PCWriteCond = 1'b1;
            PCSource    = 1'b1;
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            BranchNe    = branch_ne_q;
         end
         S_LUI: begin
            RegWrite = 1'b1;
            MemToReg = 2'b10;
         end
         S_HALT:      Halted = 1'b1;
         default: ;
      endcase
   end

   assign State = state;

endmodule

`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench for controle_multiciclo against an instruction-level reference model.
`default_nettype none

module tb_controle_multiciclo;

   logic        clk;
   logic        reset;
   logic [31:0] IMemOut;
   logic        mem_ready;
   logic        PCWrite, PCWriteCond, BranchNe, PCSource, IRWrite;
   logic        MemRead, MemWrite, RegWrite, ALUSrcA, Halted;
   logic [1:0]  MemToReg, ALUSrcB, ALUOp;
   logic [3:0]  State;

   int checks = 0;
   int errors = 0;

`ifdef WAIT_STATE_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   controle_multiciclo dut (
      .clk         (clk),
      .reset       (reset),
      .IMemOut     (IMemOut),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .BranchNe    (BranchNe),
      .PCSource    (PCSource),
      .IRWrite     (IRWrite),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .RegWrite    (RegWrite),
      .MemToReg    (MemToReg),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .Halted      (Halted),
      .State       (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bit order: PCWrite PCWriteCond BranchNe PCSource IRWrite MemRead MemWrite RegWrite
   //            MemToReg[1:0] ALUSrcA ALUSrcB[1:0] ALUOp[1:0] Halted
   function automatic logic [15:0] observed();
      return {PCWrite, PCWriteCond, BranchNe, PCSource, IRWrite, MemRead, MemWrite,
              RegWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp, Halted};
   endfunction

   function automatic logic [15:0] pack(bit pcw, bit pcc, bit bne, bit pcs, bit irw, bit mrd,
                                        bit mwr, bit rw, logic [1:0] m2r, bit sa,
                                        logic [1:0] sb, logic [1:0] op, bit h);
      return {pcw, pcc, bne, pcs, irw, mrd, mwr, rw, m2r, sa, sb, op, h};
   endfunction

   // Expected strobes for a named step of an instruction's life.
   function automatic logic [15:0] expected(int st, bit bne, bit rdy);
      bit done;
      done = !WAIT_EN || rdy;
      case (st)
         1:  return pack(done, 0, 0, 0, done, 1, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0);
         2:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0);
         3:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0);
         4:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b10, 0);
         5:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0);
         6:  return pack(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
         7:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0);
         8:  return pack(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
         9:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0);
         10: return pack(0, 1, bne, 1, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0);
         11: return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0);
         12: return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
         default: return 16'h0000;
      endcase
   endfunction

   // Sequence of states an instruction walks through, from its class.
   function automatic void path(input logic [31:0] ins, output int q[$]);
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      q = {1, 2};
      if (op == 7'b0110011)                       q.push_back(3);
      else if (op == 7'b0010011)                  q.push_back(4);
      else if (op == 7'b0000011)                  q.push_back(5);
      else if (op == 7'b0100011)                  q.push_back(5);
      else if (op == 7'b1100011 && f3 <= 3'd1)    q.push_back(10);
      else if (op == 7'b0110111)                  q.push_back(11);
      else                                        q.push_back(12);
      if (op == 7'b0110011 || op == 7'b0010011) q.push_back(9);
      if (op == 7'b0000011) begin q.push_back(6); q.push_back(7); end
      if (op == 7'b0100011) q.push_back(8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_state"}, {28'd0, State}, 32'd0);
      check({tag, "_outs"}, {16'd0, observed()}, 32'd0);
   endtask

   // Async reset: assert between edges, check immediately, hold, release, expect FETCH.
   task automatic apply_reset(input int hold_cycles);
      reset = 1'b0;
      #1;
      check_reset_state("async_rst");
      for (int i = 0; i < hold_cycles; i++) begin
         tick();
         check_reset_state("rst_hold");
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic run_instr(input logic [31:0] ins, input bit allow_abort);
      int  q[$];
      int  st;
      int  stalls;
      bit  hold;
      int  abort_at;
      path(ins, q);
      abort_at = (allow_abort && ($urandom_range(0, 7) == 0)) ? int'($urandom_range(0, q.size() - 1)) : -1;
      for (int idx = 0; idx < q.size(); idx++) begin
         st = q[idx];
         stalls = 0;
         do begin
            mem_ready = (stalls >= 6) ? 1'b1 : 1'(($urandom & 3) != 0);
            IMemOut   = (st == 2 || st == 5) ? ins : $urandom;
            #1;
            check($sformatf("state_%h_i%0d", ins, idx), {28'd0, State}, st);
            check($sformatf("outs_%h_s%0d", ins, st), {16'd0, observed()},
                  {16'd0, expected(st, ins[12], mem_ready)});
            check("pc_exclusive", {31'd0, PCWrite & PCWriteCond}, 32'd0);
            if (idx == abort_at) begin
               apply_reset(1);
               return;
            end
            hold = WAIT_EN && (st == 1 || st == 6 || st == 8) && !mem_ready;
            if (hold) stalls++;
            tick();
         end while (hold);
      end
      if (q[q.size() - 1] == 12) begin
         for (int i = 0; i < 10; i++) begin
            IMemOut   = $urandom;
            mem_ready = 1'($urandom);
            #1;
            check("halt_state", {28'd0, State}, 32'd12);
            check("halt_outs", {16'd0, observed()}, {16'd0, expected(12, 1'b0, mem_ready)});
            tick();
         end
         apply_reset(2);
      end
   endtask

   function automatic logic [31:0] random_instr();
      logic [31:0] r;
      logic [6:0]  op;
      r = $urandom;
      case ($urandom_range(0, 9))
         0, 1:    op = 7'b0110011;
         2:       op = 7'b0010011;
         3:       op = 7'b0000011;
         4:       op = 7'b0100011;
         5, 6:    op = 7'b1100011;
         7:       op = 7'b0110111;
         8:       op = 7'b1110011;
         default: op = r[6:0] ^ 7'h55;
      endcase
      if (op == 7'b1100011 && ($urandom & 3) != 0) r[14:13] = 2'b00;
      return {r[31:7], op};
   endfunction

   initial begin
      logic [31:0] directed [6];
      directed = '{32'h002081B3, 32'h00813283, 32'h00513423,
                   32'h00000063, 32'h00001063, 32'h00000073};
      reset     = 1'b0;
      IMemOut   = 32'd0;
      mem_ready = 1'b0;
      #2;
      check_reset_state("por");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_reset_state("por_hold");
      end
      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) run_instr(directed[i], 1'b0);
      for (int i = 0; i < 200; i++) run_instr(random_instr(), 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control FSM for the RV64I-subset processing unit. Sequences fetch, decode, execute, memory and write-back by driving every datapath enable and mux select (PCWrite, PCWriteCond, IRWrite, memory strobes, register-file write, ALU selects) from the current state and the instruction word on `IMemOut`. Sits beside the processing-unit datapath as its sole sequencer; one instruction in flight at a time.

## Interface
- No parameters.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces state RESET immediately.
- `IMemOut`  in  32  instruction-register contents; opcode `[6:0]`, funct3 `[14:12]`.
- `mem_ready`  in  1  memory completion strobe (used only with WAIT_STATE_EN).
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by datapath branch condition.
- `BranchNe`  out  1  1 = datapath inverts zero flag for condition (bne).
- `PCSource`  out  1  0 = ALU result, 1 = ALUOut register.
- `IRWrite`  out  1  instruction-register load.
- `MemRead`, `MemWrite`  out  1 each  data-memory strobes.
- `RegWrite`  out  1  register-file write.
- `MemToReg`  out  2  00 ALUOut, 01 MDR, 10 immediate (lui).
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 register B, 01 constant 4, 10 immediate, 11 branch immediate.
- `ALUOp`  out  2  00 add, 01 sub, 10 funct-decoded.
- `Halted`  out  1  1 in HALT.
- `State`  out  4  current state encoding (debug).

## Operation
- States (encoding): RESET 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_READ 6, WB_LOAD 7, MEM_WRITE 8, WB_ALU 9, BRANCH 10, LUI 11, HALT 12.
- Moore outputs: decoded from state register only (plus BranchNe from latched funct3). Unlisted outputs are 0.
- RESET: all outputs 0 → FETCH.
- FETCH: MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); latch funct3[0] into BranchNe register. Next by opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 or 0100011→MEM_ADDR; 1100011 with funct3 000/001→BRANCH; 0110111→LUI; anything else (incl. 1110011)→HALT.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10 → WB_ALU.
- WB_ALU: RegWrite, MemToReg=00 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_READ if opcode 0000011 else MEM_WRITE.
- MEM_READ: MemRead → WB_LOAD. WB_LOAD: RegWrite, MemToReg=01 → FETCH.
- MEM_WRITE: MemWrite → FETCH.
- BRANCH: PCWriteCond, PCSource=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, BranchNe valid → FETCH.
- LUI: RegWrite, MemToReg=10 → FETCH.
- HALT: Halted=1, all other outputs 0; exits only via reset.
- PCWrite and PCWriteCond never asserted in the same cycle.

## Timing
- Reset low: State=0 and all outputs 0 asynchronously; first FETCH on first rising edge after reset release.
- Cycles per instruction (no wait): R/I-type 4, load 5, store 4, branch 3, lui 3.
- Opcode sampled only in DECODE and MEM_ADDR; IMemOut changes elsewhere ignored.
- Reset mid-instruction: instruction abandoned, no further strobes; BranchNe register cleared.

## Configuration
- `WAIT_STATE_EN` defined: FETCH, MEM_READ, MEM_WRITE hold until `mem_ready`=1. While holding, MemRead/MemWrite stay asserted; in FETCH PCWrite and IRWrite assert only in the cycle mem_ready=1, so PC advances exactly once per fetch. mem_ready already high on entry → no added cycle.
- Undefined: mem_ready ignored; timing as in Timing section.

## Test plan
- Reset low 3 cycles, release → State 0 with all outputs 0 during reset, then State 1 with PCWrite=IRWrite=MemRead=1 on next edge.
- IMemOut=0x002081B3 (add) → states 1,2,3,9,1; RegWrite=1 only in state 9, ALUOp=10 in state 3.
- IMemOut=0x00813283 (ld) → states 1,2,5,6,7,1; MemToReg=01 with RegWrite in state 7. IMemOut=0x00513423 (sd) → 1,2,5,8,1, MemWrite only in 8.
- IMemOut=0x00000063 (beq) → BRANCH with PCWriteCond=1, BranchNe=0; 0x00001063 (bne) → BranchNe=1; PCWrite=0 in state 10.
- IMemOut=0x00000073 (ecall) → HALT, Halted=1 held 10 cycles; reset low → State 0.
- WAIT_STATE_EN, mem_ready low 3 cycles in FETCH → stays state 1, PCWrite=0 until mem_ready=1, then exactly one PCWrite pulse.
